// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: collects a bit-reversed 2^N-sample frame per bank and
// replays each completed bank in natural order, tagging bin index and frame start.
module fft_bitrev_reorder #(
    parameter int N = 3,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic         in_sof,
    input  logic [W-1:0] in_real,
    input  logic [W-1:0] in_img,
    output logic         out_valid,
    output logic         out_sof,
    output logic [N-1:0] out_idx,
    output logic [W-1:0] out_real,
    output logic [W-1:0] out_img
);

    localparam int L = 1 << N;

    typedef enum logic {IDLE, DRAIN} state_t;

    function automatic logic [N-1:0] bitrev(input logic [N-1:0] a);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = a[N-1-i];
        return r;
    endfunction

    logic [2*W-1:0] mem [0:2*L-1];

    logic [N-1:0] wr_cnt;
    logic         wr_bank;
    logic [N-1:0] wr_addr;
    logic         wr_done;
    logic [1:0]   bank_full;

    logic [N-1:0] rd_cnt;
    logic         rd_bank;
    state_t       state, state_nxt;
    logic         rd_go, rd_step, drain_last, pick_bank;

    // in_sof resyncs the frame: the sample lands at address 0 and no completion is flagged
    assign wr_addr = in_sof ? '0 : bitrev(wr_cnt);
    assign wr_done = in_valid && !in_sof && (wr_cnt == '1);

    always_ff @(posedge clk) begin
        if (in_valid) mem[{wr_bank, wr_addr}] <= {in_real, in_img};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
        end else if (in_valid) begin
            wr_cnt <= in_sof ? N'(1) : wr_cnt + N'(1);
            if (wr_done) wr_bank <= ~wr_bank;
        end
    end

    // Read FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Read FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|bank_full) state_nxt = DRAIN;
            DRAIN:   if (drain_last && !bank_full[~rd_bank]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read FSM: control outputs
    always_comb begin
        rd_go      = (state == IDLE) && (|bank_full);
        rd_step    = (state == DRAIN);
        drain_last = (state == DRAIN) && (rd_cnt == '1);
        // if both banks ever hold frames, the one the writer points at is the older
        pick_bank  = bank_full[wr_bank] ? wr_bank : ~wr_bank;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt    <= '0;
            rd_bank   <= 1'b0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_idx   <= '0;
            out_real  <= '0;
            out_img   <= '0;
        end else begin
            if (rd_go) begin
                rd_bank <= pick_bank;
                rd_cnt  <= '0;
            end
            if (rd_step) begin
                out_valid             <= 1'b1;
                out_sof               <= (rd_cnt == '0);
                out_idx               <= rd_cnt;
                {out_real, out_img}   <= mem[{rd_bank, rd_cnt}];
                rd_cnt                <= rd_cnt + N'(1);
                if (drain_last) rd_bank <= ~rd_bank;
            end else begin
                out_valid <= 1'b0;
                out_sof   <= 1'b0;
                out_idx   <= '0;
            end
        end
    end

    // Clear on drain end and set on frame completion are on different banks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_full <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (drain_last && (rd_bank == 1'(b))) bank_full[b] <= 1'b0;
                if (wr_done && (wr_bank == 1'(b)))    bank_full[b] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed and random checks of the bit-reverse reorder buffer at N=3, N=1 and N=5.
module tb_fft_bitrev_reorder;

    localparam int W = 16;

    typedef struct {
        int cyc;
        int idx;
        bit sof;
        int re;
        int im;
    } obs_t;

    typedef struct {
        int in_r;
        int in_i;
        int exp_r;
        int exp_i;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;
    int last_acc = 0;
    vec_t tab[8];

    // N=3 instance
    logic         v3, s3;
    logic [W-1:0] r3, i3;
    logic         ov3, os3;
    logic [2:0]   oi3;
    logic [W-1:0] or3, oim3;

    // shared random stream for the N=1 and N=5 instances
    logic         v6, s6;
    logic [W-1:0] r6, i6;
    logic         ov1, os1, ov5, os5;
    logic [0:0]   oi1;
    logic [4:0]   oi5;
    logic [W-1:0] or1, oim1, or5, oim5;

    fft_bitrev_reorder #(.N(3), .W(W)) u3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in_sof(s3), .in_real(r3), .in_img(i3),
        .out_valid(ov3), .out_sof(os3), .out_idx(oi3), .out_real(or3), .out_img(oim3));

    fft_bitrev_reorder #(.N(1), .W(W)) u1 (
        .clk(clk), .rst(rst), .in_valid(v6), .in_sof(s6), .in_real(r6), .in_img(i6),
        .out_valid(ov1), .out_sof(os1), .out_idx(oi1), .out_real(or1), .out_img(oim1));

    fft_bitrev_reorder #(.N(5), .W(W)) u5 (
        .clk(clk), .rst(rst), .in_valid(v6), .in_sof(s6), .in_real(r6), .in_img(i6),
        .out_valid(ov5), .out_sof(os5), .out_idx(oi5), .out_real(or5), .out_img(oim5));

    obs_t q3[$], q1[$], q5[$];

    always @(negedge clk) begin
        if (ov3 === 1'b1) q3.push_back('{cyc, int'(oi3), os3, int'($signed(or3)), int'($signed(oim3))});
        if (ov1 === 1'b1) q1.push_back('{cyc, int'(oi1), os1, int'($signed(or1)), int'($signed(oim1))});
        if (ov5 === 1'b1) q5.push_back('{cyc, int'(oi5), os5, int'($signed(or5)), int'($signed(oim5))});
    end

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic int brev(input int v, input int n);
        int r = 0;
        for (int b = 0; b < n; b++) if (v[b]) r |= (1 << (n - 1 - b));
        return r;
    endfunction

    task automatic put3(input bit v, input bit s, input int r, input int i);
        @(negedge clk);
        v3 = v; s3 = s; r3 = 16'(r); i3 = 16'(i);
        if (v) last_acc = cyc + 1;
    endtask

    task automatic idle3(input int n);
        repeat (n) put3(0, 0, 0, 0);
    endtask

    task automatic frame3(input int off, input int gap);
        for (int k = 0; k < 8; k++) begin
            put3(1, k == 0, tab[k].in_r + off, tab[k].in_i - off);
            if (gap > 0) idle3(gap);
        end
    endtask

    task automatic check_frame(input string nm, input int base, input int off, input int t0);
        if (q3.size() < base + 8) begin
            chk({nm, "_count"}, q3.size(), base + 8);
            return;
        end
        for (int j = 0; j < 8; j++) begin
            chk({nm, "_real"}, q3[base+j].re, tab[j].exp_r + off);
            chk({nm, "_img"},  q3[base+j].im, tab[j].exp_i - off);
            chk({nm, "_idx"},  q3[base+j].idx, j);
            chk({nm, "_sof"},  q3[base+j].sof, (j == 0) ? 1 : 0);
            chk({nm, "_cyc"},  q3[base+j].cyc, t0 + j);
        end
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_valid"}, ov3, 0);
        chk({nm, "_sof"},   os3, 0);
        chk({nm, "_idx"},   oi3, 0);
        chk({nm, "_real"},  or3, 0);
        chk({nm, "_img"},   oim3, 0);
    endtask

    task automatic check_rand(input string nm, input obs_t q[$], input int acc_r[$],
                              input int acc_i[$], input int n);
        int len = 1 << n;
        chk({nm, "_count"}, q.size(), acc_r.size());
        for (int m = 0; m < q.size() && m < acc_r.size(); m++) begin
            int f = m / len;
            int j = m % len;
            chk({nm, "_real"}, q[m].re, acc_r[f*len + brev(j, n)]);
            chk({nm, "_img"},  q[m].im, acc_i[f*len + brev(j, n)]);
            chk({nm, "_idx"},  q[m].idx, j);
            chk({nm, "_sof"},  q[m].sof, (j == 0) ? 1 : 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int t_a, t_b, t_c;
        bit found;
        int acc_r[$], acc_i[$];
        int er[8] = '{0, 40, 20, 60, 10, 50, 30, 70};
        int ei[8] = '{0, -4, -2, -6, -1, -5, -3, -7};
        for (int k = 0; k < 8; k++) tab[k] = '{10*k, -k, er[k], ei[k]};

        rst = 1'b1;
        v3 = 0; s3 = 0; r3 = '0; i3 = '0;
        v6 = 0; s6 = 0; r6 = '0; i6 = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        idle3(2);

        // single frame
        frame3(0, 0); t_a = last_acc;
        idle3(20);
        chk("t1_count", q3.size(), 8);
        check_frame("t1", 0, 0, t_a + 2);
        q3.delete();

        // three back-to-back frames, 24 contiguous outputs
        frame3(0, 0);   t_a = last_acc;
        frame3(100, 0); t_b = last_acc;
        frame3(200, 0); t_c = last_acc;
        idle3(40);
        chk("t2_count", q3.size(), 24);
        check_frame("t2a", 0, 0, t_a + 2);
        check_frame("t2b", 8, 100, t_a + 10);
        check_frame("t2c", 16, 200, t_a + 18);
        chk("t2_span_b", t_b, t_a + 8);
        chk("t2_span_c", t_c, t_a + 16);
        q3.delete();

        // gapped input: one sample every 3rd cycle
        frame3(300, 2); t_a = last_acc;
        idle3(20);
        chk("t3_count", q3.size(), 8);
        check_frame("t3", 0, 300, t_a + 2);
        q3.delete();

        // 5-sample fragment abandoned by a resync
        for (int k = 0; k < 5; k++) put3(1, k == 0, 900 + k, 900 + k);
        frame3(0, 0); t_a = last_acc;
        idle3(20);
        chk("t4_count", q3.size(), 8);
        check_frame("t4", 0, 0, t_a + 2);
        q3.delete();

        // async reset mid-drain at bin 3
        frame3(0, 0);
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            put3(0, 0, 0, 0);
            if (ov3 === 1'b1 && oi3 == 3'd3) found = 1;
        end
        chk("t5_reach_bin3", found, 1);
        #1 rst = 1'b1;
        #1 check_zero("t5_rst");
        #1 rst = 1'b0;
        q3.delete();
        idle3(20);
        chk("t5_flush", q3.size(), 0);
        frame3(500, 0); t_a = last_acc;
        idle3(20);
        chk("t5_count", q3.size(), 8);
        check_frame("t5", 0, 500, t_a + 2);
        q3.delete();

        // random stream into N=1 and N=5 builds
        q1.delete(); q5.delete();
        while (acc_r.size() < 128) begin
            @(negedge clk);
            if ($urandom_range(3) != 0) begin
                logic signed [W-1:0] a, b;
                a = W'($urandom);
                b = W'($urandom);
                v6 = 1'b1; r6 = a; i6 = b;
                acc_r.push_back(int'(a));
                acc_i.push_back(int'(b));
            end else begin
                v6 = 1'b0;
            end
        end
        @(negedge clk) v6 = 1'b0;
        repeat (60) @(negedge clk);
        check_rand("t6_n1", q1, acc_r, acc_i, 1);
        check_rand("t6_n5", q5, acc_r, acc_i, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
